// File: rtl/gap10_pkg.sv
// gap10 shared definitions: default sizes, derived widths, FSM state type.
// Optional build macro: GAP10_RELU_EN (clamp negative lane inputs to zero).
package gap10_pkg;

    localparam int GAP_DSP_NO = 256;
    localparam int GAP_WIDTH  = 16;
    localparam int GAP_W_IN   = 8;
    localparam int GAP_H_IN   = 8;
    localparam int GAP_CHOUT  = 512;

    localparam int PIX    = GAP_W_IN * GAP_H_IN;
    localparam int GROUPS = GAP_CHOUT / GAP_DSP_NO;
    localparam int ACC_W  = GAP_WIDTH + $clog2(PIX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } gap_state_e;

endpackage

// File: rtl/gap10_lane.sv
// gap_lane: one channel of the global average pool.
// Accumulates pixels, rounds the mean on the last pixel, holds the result.
module gap_lane
    import gap10_pkg::*;
#(
    parameter int WIDTH = GAP_WIDTH,
    parameter int AW    = ACC_W,
    parameter int SHIFT = $clog2(PIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             beat,
    input  logic             last,
    input  logic [WIDTH-1:0] ifm,
    output logic [WIDTH-1:0] ofm
);

    localparam logic signed [AW:0] RND = (AW + 1)'(1) << (SHIFT - 1);

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] x_ext;
    logic signed [AW:0]   sum_r;
    logic [WIDTH-1:0]     ofm_q, ofm_d;

    // Lane input conditioning, running sum and rounded mean.
    always_comb begin
`ifdef GAP10_RELU_EN
        x_ext = ifm[WIDTH-1] ? '0 : {{(AW - WIDTH){1'b0}}, ifm};
`else
        x_ext = {{(AW - WIDTH){ifm[WIDTH-1]}}, ifm};
`endif
        sum_r = {acc_q[AW-1], acc_q} + {x_ext[AW-1], x_ext} + RND;
        acc_d = acc_q;
        ofm_d = ofm_q;
        if (clr) begin
            acc_d = '0;
        end else if (beat) begin
            if (last) begin
                ofm_d = WIDTH'(sum_r >>> SHIFT);
                acc_d = '0;
            end else begin
                acc_d = acc_q + x_ext;
            end
        end
    end

    // Accumulator and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ofm_q <= '0;
        end else begin
            acc_q <= acc_d;
            ofm_q <= ofm_d;
        end
    end

    assign ofm = ofm_q;

endmodule

// File: rtl/gap10.sv
// gap10: global average pool over a W_IN x H_IN map, DSP_NO lanes per beat.
// Build macro GAP10_RELU_EN clamps negative inputs to zero before averaging.
module gap10
    import gap10_pkg::*;
#(
    parameter int DSP_NO = GAP_DSP_NO,
    parameter int WIDTH  = GAP_WIDTH,
    parameter int W_IN   = GAP_W_IN,
    parameter int H_IN   = GAP_H_IN,
    parameter int CHOUT  = GAP_CHOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          gap10_en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DSP_NO-1:0][WIDTH-1:0]  ifm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DSP_NO-1:0][WIDTH-1:0]  ofm,
    output logic [((CHOUT / DSP_NO) > 1 ?
                   $clog2(CHOUT / DSP_NO) : 1)-1:0] out_group,
    output logic                          frame_done
);

    localparam int LPIX   = W_IN * H_IN;
    localparam int LGRP   = CHOUT / DSP_NO;
    localparam int PW     = $clog2(LPIX);
    localparam int GW     = (LGRP > 1) ? $clog2(LGRP) : 1;
    localparam int LACC_W = WIDTH + PW;

    localparam logic [PW-1:0] PIX_LAST = PW'(LPIX - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(LGRP - 1);

    gap_state_e    state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [GW-1:0] grp_q, grp_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          frame_done_q, frame_done_d;
    logic          lane_clr, lane_beat, lane_last;

    // Frame sequencing: accumulate a group, hold its average, advance.
    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        grp_d        = grp_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        lane_clr     = 1'b0;
        lane_beat    = 1'b0;
        lane_last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gap10_en) begin
                    state_d  = ST_ACCUM;
                    pix_d    = '0;
                    grp_d    = '0;
                    lane_clr = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    lane_beat = 1'b1;
                    if (pix_q == PIX_LAST) begin
                        lane_last   = 1'b1;
                        pix_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        pix_d = pix_q + PW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (grp_q == GRP_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        grp_d    = grp_q + GW'(1);
                        pix_d    = '0;
                        lane_clr = 1'b1;
                        state_d  = ST_ACCUM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_ACCUM);
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pix_q        <= '0;
            grp_q        <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            grp_q        <= grp_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_group  = grp_q;
    assign frame_done = frame_done_q;

    for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
        gap_lane #(
            .WIDTH (WIDTH),
            .AW    (LACC_W),
            .SHIFT (PW)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (lane_clr),
            .beat (lane_beat),
            .last (lane_last),
            .ifm  (ifm[i]),
            .ofm  (ofm[i])
        );
    end

endmodule

// File: tb/tb_gap10.sv
// tb_gap10: randomized stimulus against a transaction-level average model.
// Literal expectations pin the model on known patterns.
module tb_gap10;
    import gap10_pkg::*;

    localparam int N  = GAP_DSP_NO;
    localparam int W  = GAP_WIDTH;
    localparam int P  = PIX;
    localparam int G  = GROUPS;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic gap10_en = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, frame_done;
    logic [N-1:0][W-1:0] ifm = '0;
    logic [N-1:0][W-1:0] ofm;
    logic [GW-1:0] out_group;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    gap10 dut (
        .clk        (clk),
        .rst        (rst),
        .gap10_en   (gap10_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ifm        (ifm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ofm        (ofm),
        .out_group  (out_group),
        .frame_done (frame_done)
    );

    // Reference model: 0 idle, 1 collecting pixels, 2 presenting result.
    int          m_st = 0;
    int          m_pix = 0;
    int          m_grp = 0;
    bit          m_ov = 1'b0;
    bit          m_fd = 1'b0;
    longint      m_sum[N] = '{default: 0};
    logic [W-1:0] m_ofm[N] = '{default: '0};

    function automatic longint lane_in(logic [W-1:0] v);
        longint s;
        s = longint'($signed(v));
`ifdef GAP10_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    function automatic longint floor_div(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st  <= 0;
            m_pix <= 0;
            m_grp <= 0;
            m_ov  <= 1'b0;
            m_fd  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                m_sum[i] <= 0;
                m_ofm[i] <= '0;
            end
        end else begin
            m_fd <= 1'b0;
            case (m_st)
                0: if (gap10_en) begin
                    m_st  <= 1;
                    m_pix <= 0;
                    m_grp <= 0;
                    for (int i = 0; i < N; i++) m_sum[i] <= 0;
                end
                1: if (in_valid) begin
                    if (m_pix == P - 1) begin
                        for (int i = 0; i < N; i++)
                            m_ofm[i] <= W'(floor_div(
                                m_sum[i] + lane_in(ifm[i]) + P / 2, P));
                        m_st  <= 2;
                        m_ov  <= 1'b1;
                        m_pix <= 0;
                    end else begin
                        for (int i = 0; i < N; i++)
                            m_sum[i] <= m_sum[i] + lane_in(ifm[i]);
                        m_pix <= m_pix + 1;
                    end
                end
                2: if (out_ready) begin
                    m_ov <= 1'b0;
                    if (m_grp == G - 1) begin
                        m_st <= 0;
                        m_fd <= 1'b1;
                    end else begin
                        m_grp <= m_grp + 1;
                        m_pix <= 0;
                        for (int i = 0; i < N; i++) m_sum[i] <= 0;
                        m_st <= 1;
                    end
                end
                default: m_st <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            int bad;
            chk("in_ready", 64'(in_ready), 64'(m_st == 1));
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("frame_done", 64'(frame_done), 64'(m_fd));
            chk("out_group", 64'(out_group), 64'(m_grp));
            bad = -1;
            for (int i = N - 1; i >= 0; i--)
                if (ofm[i] !== m_ofm[i]) bad = i;
            n_chk++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL ofm lane %0d at %0t: got %0h expected %0h",
                         bad, $time, ofm[bad], m_ofm[bad]);
            end
        end
    end

    function automatic logic [W-1:0] pat(int mode, int lane, int pix);
        case (mode)
            0: return W'(16'h0100);
            1: return (lane == 0) ? W'(pix) : '0;
            2: return W'(16'hFF00);
            3: return W'(16'h7FFF);
            4: return W'(16'h8000);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic run_frame(input int mode, input int vprob,
                             input int hold_dly, input int exp_lo,
                             input int exp_hi, input bit lit);
        int got = 0;
        int hc = 0;
        int cyc = 0;
        bit done = 1'b0;
        gap10_en = 1'b1;
        while (!done && cyc < 4000) begin
            @(posedge clk);
            #2;
            cyc++;
            if (frame_done) done = 1'b1;
            in_valid = ($urandom_range(99) < vprob);
            for (int i = 0; i < N; i++) ifm[i] = pat(mode, i, m_pix);
            if (out_valid) begin
                if (hc >= hold_dly) begin
                    out_ready = 1'b1;
                    if (lit) begin
                        chk("ofm_lane0_lit", 64'(ofm[0]), 64'(exp_lo));
                        chk("ofm_laneN_lit", 64'(ofm[N-1]), 64'(exp_hi));
                        chk("group_lit", 64'(out_group), 64'(got));
                    end
                    got++;
                end else begin
                    out_ready = 1'b0;
                    hc++;
                end
            end else begin
                out_ready = 1'($urandom_range(1));
                hc = 0;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_timeout mode %0d: got no frame_done", mode);
        end
    endtask

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        #2;
        chk_on = 1'b1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_ofm0", 64'(ofm[0]), 64'd0);
        rst = 1'b1;

        run_frame(0, 100, 0, 'h0100, 'h0100, 1'b1);
        run_frame(1, 100, 0, 32, 0, 1'b1);
`ifdef GAP10_RELU_EN
        run_frame(2, 80, 3, 0, 0, 1'b1);
        run_frame(3, 100, 0, 'h7FFF, 'h7FFF, 1'b1);
        run_frame(4, 100, 0, 0, 0, 1'b1);
`else
        run_frame(2, 80, 3, 'hFF00, 'hFF00, 1'b1);
        run_frame(3, 100, 0, 'h7FFF, 'h7FFF, 1'b1);
        run_frame(4, 100, 0, 'h8000, 'h8000, 1'b1);
`endif
        run_frame(5, 60, 10, 0, 0, 1'b0);
        run_frame(5, 75, 10, 0, 0, 1'b0);

        // Reset in the middle of group 0, after 40 accepted beats.
        guard = 0;
        while (!(m_st == 1 && m_pix == 40) && guard < 500) begin
            @(posedge clk);
            #2;
            guard++;
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) ifm[i] = pat(5, i, m_pix);
        end
        chk("reached_40_beats", 64'(m_pix), 64'd40);
        rst = 1'b0;
        gap10_en = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_ofm0", 64'(ofm[0]), 64'd0);
        chk("midrst_ofm_any", 64'(|ofm), 64'd0);
        chk("midrst_group", 64'(out_group), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("no_beat_without_en", 64'(in_ready), 64'd0);

        run_frame(5, 70, 2, 0, 0, 1'b0);
        run_frame(0, 90, 1, 'h0100, 'h0100, 1'b1);
        gap10_en = 1'b0;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gap10.md
GAP10 -- requirements
Module: gap10

Interface
REQ-001 Parameter DSP_NO, default 256, number of parallel channel lanes per beat.
REQ-002 Parameter WIDTH, default 16, signed Q8.8 lane width.
REQ-003 Parameter W_IN, default 8; H_IN, default 8; input spatial size, PIX = W_IN*H_IN = 64.
REQ-004 Parameter CHOUT, default 512, channels per frame, GROUPS = CHOUT/DSP_NO = 2.
REQ-005 Port clk, input, 1, single clock; all state rising-edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port gap10_en, input, 1, frame start request, sampled in IDLE only.
REQ-008 Port in_valid, input, 1, ifm beat valid.
REQ-009 Port in_ready, output, 1, block accepts a beat.
REQ-010 Port ifm, input, [WIDTH-1:0] x DSP_NO, one pixel of DSP_NO channels from conv10.
REQ-011 Port out_valid, output, 1, ofm holds a channel-group average.
REQ-012 Port out_ready, input, 1, consumer accepts ofm.
REQ-013 Port ofm, output, [WIDTH-1:0] x DSP_NO, per-channel global average.
REQ-014 Port out_group, output, $clog2(GROUPS), channel group index of current ofm.
REQ-015 Port frame_done, output, 1, one-cycle pulse after last group is accepted.

Function
REQ-016 Input order: group 0 pixels 0..PIX-1, then group 1 pixels 0..PIX-1; beat transfers when in_valid && in_ready.
REQ-017 FSM states IDLE, ACCUM, HOLD; IDLE->ACCUM on gap10_en, clearing accumulators, pixel counter and group counter.
REQ-018 in_ready = 1 only in ACCUM; gap10_en ignored outside IDLE.
REQ-019 Each transferred beat: acc[i] <= acc[i] + sign-extended ifm[i], acc width WIDTH+$clog2(PIX) = 22 bits signed, no overflow possible.
REQ-020 On transfer of pixel PIX-1: ofm[i] <= (acc[i] + ifm[i] + 32) >>> 6 (round half up), truncated to WIDTH; out_valid asserted next cycle; state -> HOLD.
REQ-021 Latency: out_valid rises exactly 1 cycle after the 64th beat of a group transfers.
REQ-022 In HOLD, ofm, out_group and out_valid stable until out_ready; out_valid && out_ready is the output transfer.
REQ-023 On output transfer with group < GROUPS-1: out_valid -> 0, group++, accumulators and pixel counter cleared, state -> ACCUM next cycle.
REQ-024 On output transfer with group = GROUPS-1: out_valid -> 0, frame_done = 1 for one cycle, state -> IDLE.
REQ-025 in_valid low in ACCUM stalls with no state change; out_ready while out_valid low has no effect.
REQ-026 gap10_en held high in IDLE the cycle after frame_done starts a new frame back-to-back.

Reset
REQ-027 rst low asynchronously forces IDLE, in_ready=0, out_valid=0, frame_done=0, out_group=0, ofm all 0, accumulators and counters 0, including mid-frame.
REQ-028 After rst release, no beat is accepted until gap10_en is seen in IDLE.

Configuration
REQ-029 Macro GAP10_RELU_EN defined: each ifm lane passes max(ifm[i], 0) before accumulation; negative inputs contribute 0.
REQ-030 GAP10_RELU_EN undefined: raw signed ifm accumulated; ofm may be negative.

Structure
REQ-031 Package gap10_pkg holds DSP_NO, WIDTH, W_IN, H_IN, CHOUT defaults, derived PIX, GROUPS, ACC_W, and the FSM state enum typedef.
REQ-032 One sub-module gap_lane (accumulator, optional ReLU, rounding, output register) generated DSP_NO times; counters and FSM in gap10 only.

Verification
REQ-033 All lanes ifm=16'h0100 (1.0) for 128 beats, out_ready=1 -> two outputs, ofm=16'h0100, out_group 0 then 1, frame_done one cycle after second.
REQ-034 Lane 0 ifm = pixel index 0..63 (raw), others 0 -> lane 0 ofm = (2016+32)>>>6 = 32, others 0.
REQ-035 All lanes 16'hFF00 (-1.0), GAP10_RELU_EN undefined -> ofm=16'hFF00; defined -> ofm=0.
REQ-036 Random in_valid gaps, out_ready low 10 cycles in HOLD -> ofm/out_valid stable, in_ready=0, no beat lost; results match model.
REQ-037 rst asserted after 40 beats of group 0 -> all outputs 0 immediately; next gap10_en frame gives correct averages.
REQ-038 Max lane 16'h7FFF for 64 beats -> ofm=16'h7FFF; min 16'h8000 -> ofm=16'h8000.
